// File: rtl/inst_rom.sv
// Instruction ROM with a byte-serial program loader. SERVE answers 1-cycle-latency fetches;
// LOAD assembles incoming bytes little-endian into words written sequentially from address 0.
module inst_rom #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_req_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_inst_o,
  output logic        rom_valid_o,
  output logic        rom_err_o,
  input  logic        load_en_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_byte_valid_i,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic [31:0] load_count_o,
  output logic        load_ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  typedef enum logic {SERVE = 1'b0, LOAD = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [23:0]    word_q, word_d;
  logic [31:0]    count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;
  logic [31:0]    rd_q;
  logic           mem_we, rd_en, addr_ok;
  logic [AW-1:0]  rd_idx;

  logic [31:0] mem [DEPTH];

  assign addr_ok = (rom_addr_i[1:0] == 2'b00) && (rom_addr_i[31:AW+2] == '0);
  assign rd_idx  = rom_addr_i[AW+1:2];

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      SERVE: begin
        // Entering LOAD takes priority, so a request on that edge is dropped.
        if (load_en_i) begin
          state_d = LOAD;
          bcnt_d  = 2'd0;
          ptr_d   = '0;
          count_d = 32'd0;
          ovf_d   = 1'b0;
        end else if (rom_req_i) begin
          vld_d = 1'b1;
          err_d = !addr_ok;
          rd_en = addr_ok;
        end
      end
      LOAD: begin
        if (!load_en_i) begin
          state_d = SERVE;
          done_d  = 1'b1;
          bcnt_d  = 2'd0;
        end else if (load_byte_valid_i) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = load_byte_i;
            2'd1: word_d[15:8]  = load_byte_i;
            2'd2: word_d[23:16] = load_byte_i;
            2'd3: begin
              if (ptr_q == PTR_FULL) begin
                ovf_d = 1'b1;
              end else begin
                mem_we  = 1'b1;
                ptr_d   = ptr_q + PW'(1);
                count_d = count_q + 32'd1;
              end
            end
          endcase
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SERVE;
      bcnt_q  <= 2'd0;
      ptr_q   <= '0;
      count_q <= 32'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Storage and read data are left unreset; outputs are masked by vld_q/err_q instead.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (mem_we) mem[ptr_q[AW-1:0]] <= {load_byte_i, word_q};
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_idx];
  end

  assign rom_inst_o   = (vld_q && !err_q) ? rd_q : NOP_INST;
  assign rom_valid_o  = vld_q;
  assign rom_err_o    = err_q;
  assign load_busy_o  = (state_q == LOAD);
  assign load_done_o  = done_q;
  assign load_count_o = count_q;
  assign load_ovf_o   = ovf_q;

endmodule

// File: tb/tb_inst_rom.sv
// Randomised bench for inst_rom: byte loads and fetches checked against an array-level memory model.
module tb_inst_rom;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst;
  logic        rom_req, rom_valid, rom_err;
  logic [31:0] rom_addr, rom_inst;
  logic        load_en, load_bv, load_busy, load_done, load_ovf;
  logic [7:0]  load_byte;
  logic [31:0] load_count;

  inst_rom #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .rom_req_i(rom_req), .rom_addr_i(rom_addr),
    .rom_inst_o(rom_inst), .rom_valid_o(rom_valid), .rom_err_o(rom_err),
    .load_en_i(load_en), .load_byte_i(load_byte), .load_byte_valid_i(load_bv),
    .load_busy_o(load_busy), .load_done_o(load_done),
    .load_count_o(load_count), .load_ovf_o(load_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk = 0;
  int fails = 0;

  logic [31:0] model_mem [DEPTH];
  int          max_def = 0;
  logic [7:0]  lbytes [$];
  logic [31:0] faddr [$];
  int          exp_count;
  logic        exp_ovf;

  // Whole-load model: every complete group of four bytes is one word, stored from index 0 until full.
  function automatic void apply_load_model();
    int words = lbytes.size() / 4;
    int nw = (words > DEPTH) ? DEPTH : words;
    for (int i = 0; i < nw; i++)
      model_mem[i] = {lbytes[4*i+3], lbytes[4*i+2], lbytes[4*i+1], lbytes[4*i]};
    if (nw > max_def) max_def = nw;
    exp_count = nw;
    exp_ovf   = (words > DEPTH);
  endfunction

  function automatic void expect_resp(input logic [31:0] a, output logic err, output logic [31:0] inst);
    if (a[1:0] != 2'b00 || a >= 32'(4*DEPTH)) begin
      err = 1'b1; inst = NOP;
    end else begin
      err = 1'b0; inst = model_mem[a >> 2];
    end
  endfunction

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 7);
    if (r == 0) return 32'($urandom_range(0, max_def - 1) * 4) | 32'($urandom_range(1, 3));
    if (r == 1) return $urandom_range(32'hFFFF_FFFF, 32'(4*DEPTH));
    return 32'($urandom_range(0, max_def - 1) * 4);
  endfunction

  function automatic logic [31:0] any_aligned();
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  task automatic fill_random(input int n);
    lbytes.delete();
    repeat (n) lbytes.push_back(8'($urandom));
  endtask

  // Drives a complete load of lbytes with random idle gaps and a live fetch request throughout.
  task automatic do_load(input string tag);
    @(negedge clk);
    load_en = 1'b1; load_bv = 1'b0; rom_req = 1'b1; rom_addr = any_aligned();
    @(negedge clk);
    chk++;
    if ({load_busy, rom_valid, load_done, load_ovf, load_count} !== {4'b1000, 32'd0}) begin
      fails++;
      $display("FAIL %s entry: busy/vld/done/ovf/count=%b/%b/%b/%b/%0d required 1/0/0/0/0",
               tag, load_busy, rom_valid, load_done, load_ovf, load_count);
    end
    foreach (lbytes[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        load_bv = 1'b0; load_byte = 8'($urandom); rom_addr = any_aligned();
        @(negedge clk);
        chk++;
        if (rom_valid !== 1'b0 || rom_inst !== NOP) begin
          fails++;
          $display("FAIL %s idle ignore: vld=%b inst=%h required 0/%h", tag, rom_valid, rom_inst, NOP);
        end
      end
      load_bv = 1'b1; load_byte = lbytes[i]; rom_addr = any_aligned();
      @(negedge clk);
      chk++;
      if (rom_valid !== 1'b0 || rom_inst !== NOP || load_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s byte ignore: vld=%b inst=%h busy=%b required 0/%h/1",
                 tag, rom_valid, rom_inst, load_busy, NOP);
      end
    end
    load_en = 1'b0; load_bv = 1'b1; load_byte = 8'($urandom); rom_addr = any_aligned();
    @(negedge clk);
    apply_load_model();
    chk++;
    if ({load_busy, load_done, rom_valid, load_ovf} !== {3'b010, exp_ovf} ||
        load_count !== 32'(exp_count) || rom_inst !== NOP) begin
      fails++;
      $display("FAIL %s exit: busy/done/vld/ovf=%b/%b/%b/%b count=%0d inst=%h required 0/1/0/%b %0d %h",
               tag, load_busy, load_done, rom_valid, load_ovf, load_count, rom_inst, exp_ovf, exp_count, NOP);
    end
    rom_req = 1'b0; load_bv = 1'b0;
    @(negedge clk);
    chk++;
    if (load_done !== 1'b0 || rom_valid !== 1'b0 || load_count !== 32'(exp_count)) begin
      fails++;
      $display("FAIL %s after exit: done=%b vld=%b count=%0d required 0/0/%0d",
               tag, load_done, rom_valid, load_count, exp_count);
    end
  endtask

  // Issues faddr back to back with occasional gaps and checks every response one cycle later.
  task automatic run_fetches(input string tag);
    logic        e_err;
    logic [31:0] e_inst;
    foreach (faddr[i]) begin
      if ($urandom_range(0, 4) == 0) begin
        rom_req = 1'b0; rom_addr = 32'($urandom);
        @(negedge clk);
        chk++;
        if ({rom_valid, rom_err} !== 2'b00 || rom_inst !== NOP) begin
          fails++;
          $display("FAIL %s gap: vld=%b err=%b inst=%h required 0/0/%h", tag, rom_valid, rom_err, rom_inst, NOP);
        end
      end
      rom_req = 1'b1; rom_addr = faddr[i];
      @(negedge clk);
      expect_resp(faddr[i], e_err, e_inst);
      chk++;
      if (rom_valid !== 1'b1 || rom_err !== e_err || rom_inst !== e_inst) begin
        fails++;
        $display("FAIL %s addr=%h: vld=%b err=%b inst=%h required 1/%b/%h",
                 tag, faddr[i], rom_valid, rom_err, rom_inst, e_err, e_inst);
      end
    end
    rom_req = 1'b0;
    @(negedge clk);
    chk++;
    if ({rom_valid, rom_err} !== 2'b00 || rom_inst !== NOP) begin
      fails++;
      $display("FAIL %s idle: vld=%b err=%b inst=%h required 0/0/%h", tag, rom_valid, rom_err, rom_inst, NOP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_req = 1'b1; rom_addr = 32'h0; load_en = 1'b0; load_bv = 1'b0; load_byte = 8'h0;
    repeat (2) @(negedge clk);
    chk++;
    if ({rom_valid, rom_err, load_busy, load_done, load_ovf} !== 5'b0 || load_count !== 32'd0 || rom_inst !== NOP) begin
      fails++;
      $display("FAIL reset: vld/err/busy/done/ovf=%b%b%b%b%b count=%0d inst=%h required 00000 0 %h",
               rom_valid, rom_err, load_busy, load_done, load_ovf, load_count, rom_inst, NOP);
    end
    rst = 1'b0; rom_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    lbytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    do_load("basic_load");
    chk++;
    if (load_count !== 32'd2) begin
      fails++;
      $display("FAIL basic_load count: got %0d required 2", load_count);
    end
  endtask

  task automatic test_fetch_basic();
    rom_req = 1'b1; rom_addr = 32'h0;
    @(negedge clk);
    rom_addr = 32'h4;
    chk++;
    if ({rom_valid, rom_err} !== 2'b10 || rom_inst !== 32'h00100513) begin
      fails++;
      $display("FAIL fetch0: vld=%b err=%b inst=%h required 1/0/00100513", rom_valid, rom_err, rom_inst);
    end
    @(negedge clk);
    rom_req = 1'b0;
    chk++;
    if ({rom_valid, rom_err} !== 2'b10 || rom_inst !== 32'h00200093) begin
      fails++;
      $display("FAIL fetch4: vld=%b err=%b inst=%h required 1/0/00200093", rom_valid, rom_err, rom_inst);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    faddr = '{32'h2, 32'(4*DEPTH), 32'h1, 32'hFFFF_FFFC, 32'h4};
    run_fetches("errors");
  endtask

  task automatic test_partial();
    fill_random(6);
    do_load("partial");
    faddr = '{32'h0, 32'h4};
    run_fetches("partial_fetch");
  endtask

  task automatic test_random_load();
    for (int it = 0; it < 3; it++) begin
      fill_random(4 * $urandom_range(2, 40) + 3);
      do_load("random_load");
      faddr.delete();
      repeat (30) faddr.push_back(pick_addr());
      run_fetches("random_fetch");
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w0;
    fill_random(6);
    w0 = {lbytes[3], lbytes[2], lbytes[1], lbytes[0]};
    @(negedge clk);
    load_en = 1'b1; load_bv = 1'b0;
    @(negedge clk);
    foreach (lbytes[i]) begin
      load_bv = 1'b1; load_byte = lbytes[i];
      @(negedge clk);
    end
    chk++;
    if (load_count !== 32'd1) begin
      fails++;
      $display("FAIL midload count: got %0d required 1", load_count);
    end
    load_en = 1'b0; load_bv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk++;
    if ({rom_valid, rom_err, load_busy, load_done, load_ovf} !== 5'b0 || load_count !== 32'd0 || rom_inst !== NOP) begin
      fails++;
      $display("FAIL midload reset: vld/err/busy/done/ovf=%b%b%b%b%b count=%0d inst=%h required 00000 0 %h",
               rom_valid, rom_err, load_busy, load_done, load_ovf, load_count, rom_inst, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk++;
      if (load_done !== 1'b0 || load_busy !== 1'b0) begin
        fails++;
        $display("FAIL midload no done: done=%b busy=%b required 0/0", load_done, load_busy);
      end
    end
    model_mem[0] = w0;
    faddr = '{32'h0, 32'h4, 32'h0};
    run_fetches("midload_fetch");
  endtask

  task automatic test_overflow();
    fill_random(4*DEPTH + 4);
    do_load("overflow");
    chk++;
    if (load_ovf !== 1'b1 || load_count !== 32'(DEPTH)) begin
      fails++;
      $display("FAIL overflow flags: ovf=%b count=%0d required 1/%0d", load_ovf, load_count, DEPTH);
    end
    faddr.delete();
    faddr.push_back(32'h0);
    faddr.push_back(32'(4*DEPTH - 4));
    faddr.push_back(32'(4*DEPTH));
    repeat (20) faddr.push_back(pick_addr());
    run_fetches("overflow_fetch");
    fill_random(4);
    do_load("after_overflow");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_fetch_basic();
    test_errors();
    test_partial();
    test_random_load();
    test_reset_midload();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
